// File: rtl/jt03_wrq_if.sv
// Host push port and YM2203 CPU bus of the jt03_wrq register-write queue.
// Handshake: host_we is a strobe with no ready; an entry is taken on every clk edge
// where host_we=1 and host_full=0, otherwise it is dropped and host_ovf latches.
interface jt03_wrq_if #(parameter int DEPTH = 8);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          host_we;
  logic [7:0]    host_reg;
  logic [7:0]    host_val;
  logic          host_full;
  logic [LW-1:0] host_level;
  logic          host_idle;
  logic          host_ovf;
  logic          host_tmo;
  logic          host_clr;
  logic [7:0]    ym_din;
  logic          ym_addr;
  logic          ym_cs_n;
  logic          ym_wr_n;
  logic [7:0]    ym_dout;
  logic [2:0]    dbg_state;

  modport master (
    output host_we, host_reg, host_val, host_clr, ym_dout,
    input  host_full, host_level, host_idle, host_ovf, host_tmo,
    input  ym_din, ym_addr, ym_cs_n, ym_wr_n, dbg_state
  );

  modport slave (
    input  host_we, host_reg, host_val, host_clr, ym_dout,
    output host_full, host_level, host_idle, host_ovf, host_tmo,
    output ym_din, ym_addr, ym_cs_n, ym_wr_n, dbg_state
  );
endinterface

// File: rtl/jt03_wrq.sv
// FIFO of {register, value} pairs replayed onto the YM2203 CPU bus with busy-flag pacing.
// Define JT03_WRQ_BUSY_EN to poll dout[7]; otherwise a fixed FIXED_WAIT tick wait is used.
module jt03_wrq #(
  parameter int DEPTH      = 8,
  parameter int ADDR_GAP   = 2,
  parameter int POLL_DLY   = 2,
  parameter int BUSY_MAX   = 255,
  parameter int FIXED_WAIT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  jt03_wrq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]  GAP_LAST = 8'(ADDR_GAP - 1);
`ifdef JT03_WRQ_BUSY_EN
  localparam logic [7:0]  POLL_LAST = 8'(POLL_DLY - 1);
  localparam logic [7:0]  BUSY_LAST = 8'(BUSY_MAX - 1);
  localparam int unused_params = FIXED_WAIT;
`else
  localparam logic [7:0]  WAIT_LAST = 8'(FIXED_WAIT - 1);
  localparam int unused_params = POLL_DLY + BUSY_MAX;
`endif

  typedef enum logic [2:0] {S_IDLE, S_AWR, S_GAP, S_DWR, S_WAIT, S_POLL} state_t;

  // Release is delayed two edges so the FSM never sees a half-released reset.
  logic [1:0] rst_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  logic run;
  assign run = cen & rst_sync_q[1];

  logic [7:0]  fifo_reg_q [DEPTH];
  logic [7:0]  fifo_val_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, level;
  logic        full, empty, push, pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign push  = bus.host_we & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q[AW-1:0]] <= bus.host_reg;
      fifo_val_q[wr_ptr_q[AW-1:0]] <= bus.host_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] held_val_q;
  logic [7:0] din_q, din_d;
  logic       addr_q, addr_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic       tmo_set;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    din_d   = din_q;
    addr_d  = addr_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    if (run) begin
      case (state_q)
        S_IDLE: if (!empty) begin
          pop     = 1'b1;
          state_d = S_AWR;
        end
        S_AWR: begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
        S_GAP: if (cnt_q == GAP_LAST) state_d = S_DWR;
               else cnt_d = cnt_q + 8'd1;
        S_DWR: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
`ifdef JT03_WRQ_BUSY_EN
        S_WAIT: if (cnt_q == POLL_LAST) begin
          state_d = S_POLL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
        S_POLL: if (!bus.ym_dout[7]) state_d = S_IDLE;
        else if (cnt_q == BUSY_LAST) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 8'd1;
`else
        S_WAIT: if (cnt_q == WAIT_LAST) state_d = S_IDLE;
                else cnt_d = cnt_q + 8'd1;
`endif
        default: state_d = S_IDLE;
      endcase

      // Bus outputs are registered from the state being entered.
      case (state_d)
        S_AWR: begin
          addr_d = 1'b0;
          din_d  = fifo_reg_q[rd_ptr_q[AW-1:0]];
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
        S_DWR: begin
          addr_d = 1'b1;
          din_d  = held_val_q;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
        S_POLL: begin
          addr_d = 1'b0;
          cs_n_d = 1'b0;
          wr_n_d = 1'b1;
        end
        default: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      held_val_q <= '0;
      din_q      <= '0;
      addr_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      if (pop) held_val_q <= fifo_val_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Sticky flags: a clear wins over a set arriving on the same edge.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ovf_q <= 1'b0;
    else if (bus.host_clr)        ovf_q <= 1'b0;
    else if (bus.host_we && full) ovf_q <= 1'b1;
  end

`ifdef JT03_WRQ_BUSY_EN
  logic tmo_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            tmo_q <= 1'b0;
    else if (bus.host_clr) tmo_q <= 1'b0;
    else if (tmo_set)      tmo_q <= 1'b1;
  end
  assign bus.host_tmo = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo   = tmo_set;
  assign bus.host_tmo = 1'b0;
`endif

  logic unused_dout;
  assign unused_dout = ^bus.ym_dout;

  assign bus.host_full  = full;
  assign bus.host_level = level;
  assign bus.host_idle  = empty && (state_q == S_IDLE);
  assign bus.host_ovf   = ovf_q;
  assign bus.ym_din     = din_q;
  assign bus.ym_addr    = addr_q;
  assign bus.ym_cs_n    = cs_n_q;
  assign bus.ym_wr_n    = wr_n_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_jt03_wrq.sv
// Self-checking bench for jt03_wrq: scoreboard of expected bus writes plus
// edge-exact timing checks; expectations follow JT03_WRQ_BUSY_EN when defined.
module tb_jt03_wrq;
  localparam int DEPTH      = 8;
  localparam int ADDR_GAP   = 2;
  localparam int POLL_DLY   = 2;
  localparam int BUSY_MAX   = 255;
  localparam int FIXED_WAIT = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cen   = 1'b0;

  jt03_wrq_if #(.DEPTH(DEPTH)) bus ();

  jt03_wrq #(
    .DEPTH(DEPTH), .ADDR_GAP(ADDR_GAP), .POLL_DLY(POLL_DLY),
    .BUSY_MAX(BUSY_MAX), .FIXED_WAIT(FIXED_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  int         awr_log[$];
  int         dwr_log[$];
  int         edge_n   = 0;
  int         cen_div  = 1;
  int         phase    = 0;
  logic       prev_wr_n = 1'b1;
  int         low_cnt  = 0;
  int         busy_len = 12;
  int         busy_rem = 0;
  bit         busy_stuck = 1'b0;

  // One clk edge; observe the bus 1 time unit later, run the scoreboard and busy model.
  task automatic step();
    logic [8:0] exp_v;
    cen = (phase == 0);
    @(posedge clk);
    #1;
    edge_n++;
    phase = (phase + 1 >= cen_div) ? 0 : phase + 1;
    if (bus.ym_wr_n === 1'b0 && prev_wr_n === 1'b1) begin
      if (bus.ym_addr) dwr_log.push_back(edge_n);
      else             awr_log.push_back(edge_n);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got addr=%0b din=%02h, expected nothing", bus.ym_addr, bus.ym_din);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.ym_addr, bus.ym_din} !== exp_v) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0b din=%02h, expected addr=%0b din=%02h",
                   bus.ym_addr, bus.ym_din, exp_v[8], exp_v[7:0]);
        end
      end
      if (bus.ym_addr) busy_rem = busy_len;
    end else if (busy_rem > 0) busy_rem--;
    if (bus.ym_wr_n === 1'b0) low_cnt++;
    else if (prev_wr_n === 1'b0) begin
      n_tests++;
      if (low_cnt != cen_div) begin
        n_fail++;
        $display("FAIL strobe_width: got %0d clk, expected %0d clk", low_cnt, cen_div);
      end
      low_cnt = 0;
    end
    prev_wr_n   = bus.ym_wr_n;
    bus.ym_dout = {(busy_stuck || busy_rem > 0), 7'h00};
  endtask

  task automatic push_pair(input logic [7:0] r, input logic [7:0] v);
    bus.host_we  = 1'b1;
    bus.host_reg = r;
    bus.host_val = v;
    exp_q.push_back({1'b0, r});
    exp_q.push_back({1'b1, v});
    step();
    bus.host_we = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.host_idle !== 1'b1) && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || bus.host_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d writes pending idle=%0b, expected 0 pending idle=1",
               name, exp_q.size(), bus.host_idle);
    end
  endtask

  task automatic wait_dwr(input int n, input string name);
    int k;
    k = 0;
    while (dwr_log.size() < n && k < 50) begin
      step();
      k++;
    end
    n_tests++;
    if (dwr_log.size() < n) begin
      n_fail++;
      $display("FAIL %s_dwr_wait: got %0d data writes, expected %0d", name, dwr_log.size(), n);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    awr_log.delete();
    dwr_log.delete();
    busy_rem  = 0;
    low_cnt   = 0;
    prev_wr_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.host_we  = 1'b0;
    bus.host_reg = 8'h00;
    bus.host_val = 8'h00;
    bus.host_clr = 1'b0;
    bus.ym_dout  = 8'h00;
    repeat (3) step();
    n_tests++;
    if ({bus.ym_din, bus.ym_addr, bus.ym_cs_n, bus.ym_wr_n} !== 11'b0000_0000_011) begin
      n_fail++;
      $display("FAIL reset_bus: got din=%02h addr=%0b cs_n=%0b wr_n=%0b, expected 00 0 1 1",
               bus.ym_din, bus.ym_addr, bus.ym_cs_n, bus.ym_wr_n);
    end
    n_tests++;
    if ({bus.host_level, bus.host_full, bus.host_idle, bus.host_ovf, bus.host_tmo, bus.dbg_state} !== 11'b0000_0100_000) begin
      n_fail++;
      $display("FAIL reset_host: got level=%0d full=%0b idle=%0b ovf=%0b tmo=%0b state=%0d, expected 0 0 1 0 0 0",
               bus.host_level, bus.host_full, bus.host_idle, bus.host_ovf, bus.host_tmo, bus.dbg_state);
    end
    rst_n = 1'b1;
    repeat (5) step();
    n_tests++;
    if (bus.ym_cs_n !== 1'b1 || bus.host_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_quiet: got cs_n=%0b idle=%0b, expected 1 1", bus.ym_cs_n, bus.host_idle);
    end
  endtask

  task automatic test_single();
`ifdef JT03_WRQ_BUSY_EN
    localparam int IDLE_K = 4 + 12 + 1;
`else
    localparam int IDLE_K = 4 + 1 + FIXED_WAIT;
`endif
    clear_sb();
    cen_div  = 1;
    busy_len = 12;
    push_pair(8'h28, 8'hF1);
    for (int k = 1; k <= IDLE_K + 3; k++) begin
      step();
      if (k == 1) begin
        n_tests++;
        if ({bus.ym_addr, bus.ym_din, bus.ym_cs_n, bus.ym_wr_n} !== {1'b0, 8'h28, 2'b00}) begin
          n_fail++;
          $display("FAIL single_awr: got addr=%0b din=%02h cs_n=%0b wr_n=%0b, expected 0 28 0 0",
                   bus.ym_addr, bus.ym_din, bus.ym_cs_n, bus.ym_wr_n);
        end
      end
      if (k == 2) begin
        n_tests++;
        if ({bus.ym_cs_n, bus.ym_wr_n} !== 2'b11) begin
          n_fail++;
          $display("FAIL single_gap: got cs_n=%0b wr_n=%0b, expected 1 1", bus.ym_cs_n, bus.ym_wr_n);
        end
      end
      if (k == 4) begin
        n_tests++;
        if ({bus.ym_addr, bus.ym_din, bus.ym_cs_n, bus.ym_wr_n} !== {1'b1, 8'hF1, 2'b00}) begin
          n_fail++;
          $display("FAIL single_dwr: got addr=%0b din=%02h cs_n=%0b wr_n=%0b, expected 1 f1 0 0",
                   bus.ym_addr, bus.ym_din, bus.ym_cs_n, bus.ym_wr_n);
        end
      end
      if (k == 7) begin
        n_tests++;
`ifdef JT03_WRQ_BUSY_EN
        if ({bus.ym_addr, bus.ym_cs_n, bus.ym_wr_n} !== 3'b001) begin
          n_fail++;
          $display("FAIL single_poll: got addr=%0b cs_n=%0b wr_n=%0b, expected 0 0 1",
                   bus.ym_addr, bus.ym_cs_n, bus.ym_wr_n);
        end
`else
        if ({bus.ym_cs_n, bus.ym_wr_n} !== 2'b11) begin
          n_fail++;
          $display("FAIL single_wait: got cs_n=%0b wr_n=%0b, expected 1 1", bus.ym_cs_n, bus.ym_wr_n);
        end
`endif
      end
      if (k == IDLE_K - 1) begin
        n_tests++;
        if (bus.host_idle !== 1'b0) begin
          n_fail++;
          $display("FAIL single_busy_before: got idle=%0b at t+%0d, expected 0", bus.host_idle, k);
        end
      end
      if (k == IDLE_K) begin
        n_tests++;
        if (bus.host_idle !== 1'b1 || bus.dbg_state !== 3'd0) begin
          n_fail++;
          $display("FAIL single_idle: got idle=%0b state=%0d at t+%0d, expected 1 0",
                   bus.host_idle, bus.dbg_state, k);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_sb_left: got %0d writes pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
`ifdef JT03_WRQ_BUSY_EN
    localparam int GAP_EXP = 40 + 2;
`else
    localparam int GAP_EXP = 1 + FIXED_WAIT + 1;
`endif
    clear_sb();
    busy_len = 40;
    push_pair(8'hA1, 8'h11);
    push_pair(8'hA2, 8'h22);
    drain(400, "b2b");
    n_tests++;
    if (awr_log.size() < 2 || dwr_log.size() < 1) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d addr writes, expected 2", awr_log.size());
    end else if (awr_log[1] - dwr_log[0] != GAP_EXP) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d ticks from data write to next addr write, expected %0d",
               awr_log[1] - dwr_log[0], GAP_EXP);
    end
    busy_len = 12;
  endtask

  task automatic test_timeout();
    int d;
    clear_sb();
    busy_stuck = 1'b1;
`ifdef JT03_WRQ_BUSY_EN
    push_pair(8'hB1, 8'h33);
    push_pair(8'hB2, 8'h44);
    wait_dwr(1, "tmo");
    d = (dwr_log.size() > 0) ? dwr_log[0] : edge_n;
    while (edge_n < d + 2 + BUSY_MAX) step();
    n_tests++;
    if (bus.host_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: got tmo=%0b one tick before timeout, expected 0", bus.host_tmo);
    end
    step();
    n_tests++;
    if (bus.host_tmo !== 1'b1 || bus.dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL tmo_set: got tmo=%0b state=%0d, expected 1 0", bus.host_tmo, bus.dbg_state);
    end
    busy_stuck = 1'b0;
    drain(200, "tmo");
    n_tests++;
    if (awr_log.size() < 2 || awr_log[1] != d + 4 + BUSY_MAX) begin
      n_fail++;
      $display("FAIL tmo_next: got %0d addr writes (second at %0d), expected 2 (second at %0d)",
               awr_log.size(), (awr_log.size() > 1) ? awr_log[1] : -1, d + 4 + BUSY_MAX);
    end
    bus.host_clr = 1'b1;
    step();
    bus.host_clr = 1'b0;
    n_tests++;
    if (bus.host_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clr: got tmo=%0b, expected 0", bus.host_tmo);
    end
`else
    push_pair(8'hB1, 8'h33);
    drain(100, "tmo");
    busy_stuck = 1'b0;
    d = 0;
    n_tests++;
    if (bus.host_tmo !== 1'b0 || bus.ym_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_fixed: got tmo=%0b cs_n=%0b with busy stuck, expected 0 1",
               bus.host_tmo, bus.ym_cs_n);
    end
`endif
  endtask

  task automatic test_overflow();
    clear_sb();
    busy_len = 60;
    push_pair(8'h30, 8'h01);
    wait_dwr(1, "ovf");
    busy_len = 5;
    for (int i = 0; i < 8; i++) begin
      bus.host_we  = 1'b1;
      bus.host_reg = 8'h40 + 8'(i);
      bus.host_val = 8'(i * 3);
      exp_q.push_back({1'b0, 8'h40 + 8'(i)});
      exp_q.push_back({1'b1, 8'(i * 3)});
      step();
    end
    n_tests++;
    if (bus.host_level !== 4'd8 || bus.host_full !== 1'b1 || bus.host_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: got level=%0d full=%0b ovf=%0b, expected 8 1 0",
               bus.host_level, bus.host_full, bus.host_ovf);
    end
    bus.host_reg = 8'h55;
    bus.host_val = 8'h55;
    bus.host_clr = 1'b1;
    step();
    bus.host_clr = 1'b0;
    n_tests++;
    if (bus.host_ovf !== 1'b0 || bus.host_level !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_clr_prio: got ovf=%0b level=%0d, expected 0 8", bus.host_ovf, bus.host_level);
    end
    step();
    bus.host_we = 1'b0;
    n_tests++;
    if (bus.host_ovf !== 1'b1 || bus.host_level !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_drop: got ovf=%0b level=%0d, expected 1 8", bus.host_ovf, bus.host_level);
    end
    bus.host_clr = 1'b1;
    step();
    bus.host_clr = 1'b0;
    n_tests++;
    if (bus.host_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got ovf=%0b, expected 0", bus.host_ovf);
    end
    drain(1500, "ovf");
    busy_len = 12;
  endtask

  task automatic test_cen_div();
    clear_sb();
    cen_div = 3;
    phase   = 0;
    push_pair(8'hC1, 8'h5C);
    push_pair(8'hC2, 8'hA3);
    drain(1200, "cen");
    n_tests++;
    if (awr_log.size() < 1 || dwr_log.size() < 1 || dwr_log[0] - awr_log[0] != 3 * (1 + ADDR_GAP)) begin
      n_fail++;
      $display("FAIL cen_spacing: got addr->data %0d clk, expected %0d clk",
               (awr_log.size() > 0 && dwr_log.size() > 0) ? dwr_log[0] - awr_log[0] : -1, 3 * (1 + ADDR_GAP));
    end
    cen_div = 1;
    phase   = 0;
  endtask

  task automatic test_reset_gap();
    int seen;
    clear_sb();
    push_pair(8'h28, 8'h5A);
    push_pair(8'h29, 8'h5B);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.ym_din, bus.ym_cs_n, bus.ym_wr_n} !== {8'h00, 2'b11} || bus.host_level !== 4'd0) begin
      n_fail++;
      $display("FAIL rstgap_async: got din=%02h cs_n=%0b wr_n=%0b level=%0d, expected 00 1 1 0",
               bus.ym_din, bus.ym_cs_n, bus.ym_wr_n, bus.host_level);
    end
    clear_sb();
    repeat (3) step();
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.ym_cs_n === 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0 || awr_log.size() != 0 || bus.host_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rstgap_quiet: got %0d selected cycles idle=%0b, expected 0 1", seen, bus.host_idle);
    end
  endtask

  task automatic test_reset_sync();
    clear_sb();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    push_pair(8'h2A, 8'h77);
    step();
    n_tests++;
    if (bus.ym_cs_n !== 1'b1 || bus.dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL rstsync_hold: got cs_n=%0b state=%0d on 2nd edge after release, expected 1 0",
               bus.ym_cs_n, bus.dbg_state);
    end
    step();
    n_tests++;
    if ({bus.ym_cs_n, bus.ym_din} !== {1'b0, 8'h2A}) begin
      n_fail++;
      $display("FAIL rstsync_move: got cs_n=%0b din=%02h on 3rd edge after release, expected 0 2a",
               bus.ym_cs_n, bus.ym_din);
    end
    drain(200, "rstsync");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_cen_div();
    test_reset_gap();
    test_reset_sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
